mem_ctrl: RTL and testbench

//   Single arbiter between the core and the byte-wide unified RAM/IO port.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_load_ext.sv | 21 ++
 rtl/mem_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-serial memory controller.
// Length codes, FSM and requester encodings, IO region tag and byte helper.
package mem_ctrl_pkg;

    localparam logic [2:0]  LEN_B     = 3'd1;
    localparam logic [2:0]  LEN_H     = 3'd2;
    localparam logic [2:0]  LEN_W     = 3'd4;
    localparam logic [1:0]  IO_REGION = 2'b11;
    localparam logic [31:0] NULL32    = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    // Address bits [17:16] select the IO window.
    function automatic logic is_io(input logic [1:0] tag);
        return tag == IO_REGION;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w,
                                            input logic [1:0]  idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational sign/zero extension of assembled load data.
// Ports: data_i raw word, len_i byte count, sgn_i signed, data_o result.
module mem_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  len_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (len_i)
            LEN_B:   data_o = {{24{sgn_i & data_i[7]}}, data_i[7:0]};
            LEN_H:   data_o = {{16{sgn_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter between instruction fetch and load/store buffer and a
// byte-wide RAM/IO port. Each access is serialised into 1-4 byte cycles.
// Ports: clk/rst (sync, active-high), rdy freeze, jump_wrong flush,
//   mem_din/mem_dout/mem_a/mem_wr RAM side, io_buffer_full UART status,
//   if_req/if_addr/if_done/if_data fetch side,
//   lsb_read/lsb_write/lsb_len/lsb_addr/lsb_wdata/lsb_signed/lsb_done/
//   lsb_rdata load/store side.
// Build option MEM_IO_BUF_EN: throttle stores into the IO window on
//   io_buffer_full and insert a dead cycle between back-to-back IO writes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsb_read,
    input  logic              lsb_write,
    input  logic [2:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [DATA_W-1:0] lsb_wdata,
    input  logic              lsb_signed,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_rdata
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sgn_q, sgn_d;
    logic              replay_q, replay_d;

    logic [ADDR_W-1:0] cur_a;
    logic [1:0]        prev;
    logic              last_rd;
    logic              last_wr;
    logic              wr_ok;
    logic              wr_go;
    logic              rd_st;

    assign cur_a   = addr_q + ADDR_W'(cnt_q);
    assign prev    = cnt_q[1:0] - 2'd1;
    assign last_rd = (cnt_q >= len_q);
    assign last_wr = ((cnt_q + 3'd1) >= len_q);
    assign rd_st   = (state_q == ST_LOAD) || (state_q == ST_FETCH);

`ifdef MEM_IO_BUF_EN
    logic io_gap_q, io_gap_d;
    logic cur_io;

    assign cur_io = is_io(cur_a[17:16]);
    assign wr_ok  = !(cur_io && (io_buffer_full || io_gap_q));

    // Remembers that the previous cycle wrote to IO, forcing a gap.
    always_comb begin
        io_gap_d = io_gap_q;
        if (rdy) begin
            io_gap_d = wr_go && cur_io;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_gap_q <= 1'b0;
        end else begin
            io_gap_q <= io_gap_d;
        end
    end
`else
    logic unused_io;

    assign unused_io = io_buffer_full;
    assign wr_ok     = 1'b1;
`endif

    assign wr_go = rdy && (state_q == ST_STORE) && wr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FETCH;
            cnt_q    <= 3'd0;
            len_q    <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            sgn_q    <= 1'b0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            sgn_q    <= sgn_d;
            replay_q <= replay_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        sgn_d    = sgn_q;
        replay_d = replay_q;
        if (!rdy) begin
            // The byte in flight is lost while frozen; fetch it again.
            if (rd_st && (cnt_q != 3'd0)) begin
                replay_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d    = 3'd0;
                    replay_d = 1'b0;
                    if (lsb_write) begin
                        state_d = ST_STORE;
                        op_d    = OP_STORE;
                        addr_d  = lsb_addr;
                        len_d   = lsb_len;
                        wdata_d = lsb_wdata;
                        sgn_d   = lsb_signed;
                    end else if (lsb_read && !jump_wrong) begin
                        state_d = ST_LOAD;
                        op_d    = OP_LOAD;
                        addr_d  = lsb_addr;
                        len_d   = lsb_len;
                        sgn_d   = lsb_signed;
                        data_d  = DATA_W'(NULL32);
                    end else if (if_req && !jump_wrong) begin
                        state_d = ST_FETCH;
                        op_d    = OP_FETCH;
                        addr_d  = if_addr;
                        len_d   = LEN_W;
                        sgn_d   = 1'b0;
                        data_d  = DATA_W'(NULL32);
                    end
                end
                ST_FETCH, ST_LOAD: begin
                    if (jump_wrong) begin
                        state_d  = ST_IDLE;
                        cnt_d    = 3'd0;
                        replay_d = 1'b0;
                    end else if (replay_q) begin
                        replay_d = 1'b0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            data_d[{prev, 3'b000} +: 8] = mem_din;
                        end
                        if (last_rd) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_STORE: begin
                    if (wr_go) begin
                        if (last_wr) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        if_done  = 1'b0;
        lsb_done = 1'b0;
        case (state_q)
            ST_FETCH, ST_LOAD: begin
                if (replay_q) begin
                    mem_a = cur_a - ADDR_W'(1);
                end else if (!last_rd) begin
                    mem_a = cur_a;
                end
            end
            ST_STORE: begin
                mem_a    = cur_a;
                mem_dout = byte_sel(wdata_q, cnt_q[1:0]);
                mem_wr   = wr_go;
            end
            ST_DONE: begin
                if_done  = rdy && (op_q == OP_FETCH) && !jump_wrong;
                lsb_done = rdy && ((op_q == OP_STORE) ||
                           ((op_q == OP_LOAD) && !jump_wrong));
            end
            default: begin
                mem_a = '0;
            end
        endcase
    end

    assign if_data = data_q;

    mem_load_ext u_ext (
        .data_i (data_q),
        .len_i  (len_q),
        .sgn_i  (sgn_q),
        .data_o (lsb_rdata)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte RAM model,
// directed cases and randomised traffic against a reference memory image.
module tb_mem_ctrl;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        rdy = 1;
    logic        jump_wrong = 0;
    logic [7:0]  mem_din = 0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full = 0;
    logic        if_req = 0;
    logic [31:0] if_addr = 0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_read = 0;
    logic        lsb_write = 0;
    logic [2:0]  lsb_len = 0;
    logic [31:0] lsb_addr = 0;
    logic [31:0] lsb_wdata = 0;
    logic        lsb_signed = 0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int    ncmp = 0;
    int    nerr = 0;
    bit    rnd_rdy = 0;
    resp_t exp_q[$];
    wr_t   wq[$];

    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl [logic [31:0]];

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jump_wrong     (jump_wrong),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_read       (lsb_read),
        .lsb_write      (lsb_write),
        .lsb_len        (lsb_len),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_signed     (lsb_signed),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mdl_rd(logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] mdl_load(logic [31:0] a, int len, bit sg);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < len; k++) begin
            v = v + (32'(mdl_rd(a + 32'(k))) << (8 * k));
        end
        if (sg && len == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        if (sg && len == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // RAM: write on mem_wr, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes and completions as the DUT shows them.
    always @(negedge clk) begin
        wr_t   w;
        resp_t r;
        if (!rst) begin
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_write: got %h@%h want none",
                             mem_dout, mem_a);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_a, w.a);
                    chk("wr_data", {24'h0, mem_dout}, {24'h0, w.d});
                end
            end
            if (if_done || lsb_done) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_done: got if=%0b lsb=%0b want none",
                             if_done, lsb_done);
                end else begin
                    r = exp_q.pop_front();
                    chk("done_port", {31'h0, if_done},
                        {31'h0, r.kind == K_FETCH});
                    if (r.kind == K_FETCH) chk("if_data", if_data, r.data);
                    if (r.kind == K_LOAD) chk("lsb_rdata", lsb_rdata, r.data);
                end
            end
        end
    end

    task automatic model_issue(input int kind, input logic [31:0] a,
                               input int len, input logic [31:0] wd,
                               input bit sg);
        resp_t r;
        wr_t   w;
        r.kind = kind;
        r.data = 0;
        if (kind == K_STORE) begin
            for (int k = 0; k < len; k++) begin
                w.a = a + 32'(k);
                w.d = 8'((wd >> (8 * k)) & 32'hFF);
                mdl[w.a] = w.d;
                wq.push_back(w);
            end
        end else if (kind == K_LOAD) begin
            r.data = mdl_load(a, len, sg);
        end else begin
            r.data = mdl_load(a, 4, 1'b0);
        end
        exp_q.push_back(r);
    endtask

    task automatic do_req(input int kind, input logic [31:0] a,
                          input int len, input logic [31:0] wd,
                          input bit sg, input int jw_n, output int lat);
        model_issue(kind, a, len, wd, sg);
        @(posedge clk);
        #1;
        lsb_len    = 3'(len);
        lsb_addr   = a;
        lsb_wdata  = wd;
        lsb_signed = sg;
        if_addr    = a;
        if_req     = (kind == K_FETCH);
        lsb_read   = (kind == K_LOAD);
        lsb_write  = (kind == K_STORE);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if_done || lsb_done) begin
                lat = n;
                break;
            end
            jump_wrong = (n == jw_n);
        end
        jump_wrong = 0;
        if (lat < 0) begin
            ncmp++;
            nerr++;
            $display("FAIL timeout: got no done want done (kind %0d @%h)", kind, a);
        end
        @(posedge clk);
        #1;
        if_req    = 0;
        lsb_read  = 0;
        lsb_write = 0;
    endtask

    initial begin
        int          lat;
        int          kind;
        int          len;
        logic [31:0] a;
        bit          got;
        int          lens[3] = '{1, 2, 4};

        // Reset, with requests pending: reset must win.
        if_req    = 1;
        lsb_write = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wr", {31'h0, mem_wr}, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", {24'h0, mem_dout}, 0);
        chk("rst_if_done", {31'h0, if_done}, 0);
        chk("rst_lsb_done", {31'h0, lsb_done}, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_lsb_rdata", lsb_rdata, 0);
        if_req    = 0;
        lsb_write = 0;
        @(posedge clk);
        #1 rst = 0;

        ram[32'h100] = 8'h78; mdl[32'h100] = 8'h78;
        ram[32'h101] = 8'h56; mdl[32'h101] = 8'h56;
        ram[32'h102] = 8'h34; mdl[32'h102] = 8'h34;
        ram[32'h103] = 8'h12; mdl[32'h103] = 8'h12;
        ram[32'h200] = 8'h80; mdl[32'h200] = 8'h80;
        ram[32'h204] = 8'hFF; mdl[32'h204] = 8'hFF;
        ram[32'h205] = 8'h7F; mdl[32'h205] = 8'h7F;
        ram[32'h302] = 8'h77; mdl[32'h302] = 8'h77;

        // Word load and its latency.
        do_req(K_LOAD, 32'h100, 4, 0, 0, -1, lat);
        chk("load_w_lat", 32'(lat), 6);
        chk("load_w_val", lsb_rdata, 32'h1234_5678);

        // Extension cases.
        do_req(K_LOAD, 32'h200, 1, 0, 1, -1, lat);
        chk("load_b_lat", 32'(lat), 3);
        do_req(K_LOAD, 32'h200, 1, 0, 0, -1, lat);
        do_req(K_LOAD, 32'h204, 2, 0, 1, -1, lat);

        // Half store leaves the next byte untouched.
        do_req(K_STORE, 32'h300, 2, 32'hAABB_CCDD, 0, -1, lat);
        chk("store_h_lat", 32'(lat), 3);
        chk("store_h_keep", {24'h0, ram_rd(32'h302)}, 32'h77);

        // Store and fetch collide: store first, fetch sees its data.
        model_issue(K_STORE, 32'h302, 2, 32'h0000_1234, 0);
        model_issue(K_FETCH, 32'h300, 4, 0, 0);
        @(posedge clk);
        #1;
        lsb_write = 1; lsb_len = 2; lsb_addr = 32'h302;
        lsb_wdata = 32'h0000_1234; if_req = 1; if_addr = 32'h300;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (lsb_done || if_done) begin
                got = lsb_done;
                break;
            end
        end
        chk("collide_store_first", {31'h0, got}, 1);
        @(posedge clk);
        #1 lsb_write = 0;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (if_done) begin
                got = 1;
                break;
            end
        end
        chk("collide_fetch_done", {31'h0, got}, 1);
        @(posedge clk);
        #1 if_req = 0;

        // Flush during byte 2 of a word load: abort, no completion.
        @(posedge clk);
        #1;
        lsb_read = 1; lsb_len = 4; lsb_addr = 32'h100; lsb_signed = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 3) begin
                chk("jw_point", mem_a, 32'h102);
                jump_wrong = 1;
                lsb_read   = 0;
            end
        end
        @(negedge clk);
        jump_wrong = 0;
        chk("jw_abort_idle", mem_a, 0);
        repeat (8) @(negedge clk);

        // Flush during a store does not stop it.
        do_req(K_STORE, 32'h500, 4, $urandom, 0, 2, lat);
        chk("jw_store_lat", 32'(lat), 5);

        // IO window store with a full buffer for three cycles.
        io_full = 1;
        fork
            begin
                @(posedge clk);
                repeat (4) @(posedge clk);
                #1 io_full = 0;
            end
        join_none
        do_req(K_STORE, 32'h30000, 1, 32'h41, 0, -1, lat);
`ifdef MEM_IO_BUF_EN
        chk("io_full_lat", 32'(lat), 5);
`else
        chk("io_full_lat", 32'(lat), 2);
`endif
        do_req(K_STORE, 32'h30010, 4, 32'h4443_4241, 0, -1, lat);
`ifdef MEM_IO_BUF_EN
        chk("io_gap_lat", 32'(lat), 8);
`else
        chk("io_gap_lat", 32'(lat), 5);
`endif

        // Random traffic with random freezes and address wrap.
        rnd_rdy = 1;
        for (int t = 0; t < 120; t++) begin
            kind = int'($urandom_range(0, 2));
            len  = lens[$urandom_range(0, 2)];
            if ($urandom_range(0, 15) == 0) begin
                a = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
            end else begin
                a = 32'h1000 + 32'($urandom_range(0, 63));
            end
            do_req(kind, a, len, $urandom, 1'($urandom_range(0, 1)), -1, lat);
        end
        rnd_rdy = 0;
        @(posedge clk);
        #2 rdy = 1;
        repeat (4) @(negedge clk);

        chk("exp_left", 32'(exp_q.size()), 0);
        chk("wr_left", 32'(wq.size()), 0);
        foreach (mdl[x]) begin
            chk("ram_image", {24'h0, ram_rd(x)}, {24'h0, mdl[x]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
